mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_pkg.sv | 90 +++++++++
 rtl/mips_alu_dec.sv | 30 +++
 rtl/mips_mc_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// ALU control codes, opcode/funct values, datapath mux encodings and the
// bundle of registered control outputs.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JAL    = 4'd11,
        ST_JR     = 4'd12,
        ST_HALT   = 4'd13,
        ST_ERR    = 4'd14
    } state_e;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // Register-file destination select
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    // Write-back data select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Control outputs that are held in registers (everything except pc_we/ir_we)
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       halted;
        logic       err;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct to ALU control decode. valid is low for any funct that the
// controller does not execute through the EXEC path (including JR).
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       valid
);

    // Map funct to ALU operation and flag unsupported codes
    always_comb begin
        alu_ctrl = ALU_AND;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_SLL:  alu_ctrl = ALU_SLL;
            FN_SRL:  alu_ctrl = ALU_SRL;
            default: begin
                alu_ctrl = ALU_AND;
                valid    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit. Moore-style control outputs are registered
// from the next state, so only pc_we and ir_we react to inputs within the
// cycle. A memory-wait counter turns an unanswered request into a sticky
// error halt once WAIT_MAX consecutive wait cycles have elapsed.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       halted,
    output logic       err,
    output logic [3:0] state
);

    // The WAIT_MAX-th consecutive wait cycle is the one that times out
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e     state_r;
    state_e     state_nxt_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_nxt_s;
    logic       run_r;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_nxt_s;
    logic [2:0] dec_alu_ctrl_s;
    logic       dec_valid_s;
    logic       in_mem_s;
    logic       timeout_s;

    mips_alu_dec u_alu_dec (
        .funct    (funct),
        .alu_ctrl (dec_alu_ctrl_s),
        .valid    (dec_valid_s)
    );

    // Reset-release qualifier: keeps RST for one edge so FETCH starts on the second edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // State, wait counter and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RST;
            wait_cnt_r <= 8'd0;
            ctrl_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
        end
    end

    // Memory wait tracking; mem_ready takes priority over a timeout
    always_comb begin
        in_mem_s       = (state_r == ST_FETCH) || (state_r == ST_MEMRD) || (state_r == ST_MEMWR);
        timeout_s      = 1'b0;
        wait_cnt_nxt_s = 8'd0;
        if (in_mem_s && !mem_ready) begin
            if (wait_cnt_r >= WAIT_LAST) begin
                timeout_s = 1'b1;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + 8'd1;
            end
        end else begin
            wait_cnt_nxt_s = 8'd0;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RST:    state_nxt_s = run_r ? ST_FETCH : ST_RST;
            ST_FETCH:  state_nxt_s = mem_ready ? ST_DECODE : (timeout_s ? ST_ERR : ST_FETCH);
            ST_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_nxt_s = ST_JR;
                        end else if (dec_valid_s) begin
                            state_nxt_s = ST_EXEC;
                        end else begin
                            state_nxt_s = ST_HALT;
                        end
                    end
                    OP_LW, OP_SW, OP_ADDI: state_nxt_s = ST_MEMADR;
                    OP_BEQ, OP_BNE:        state_nxt_s = ST_BRANCH;
                    OP_JAL:                state_nxt_s = ST_JAL;
                    default:               state_nxt_s = ST_HALT;
                endcase
            end
            ST_MEMADR: begin
                case (op)
                    OP_LW:   state_nxt_s = ST_MEMRD;
                    OP_SW:   state_nxt_s = ST_MEMWR;
                    OP_ADDI: state_nxt_s = ST_ADDIWB;
                    default: state_nxt_s = ST_HALT;
                endcase
            end
            ST_MEMRD:  state_nxt_s = mem_ready ? ST_MEMWB : (timeout_s ? ST_ERR : ST_MEMRD);
            ST_MEMWB:  state_nxt_s = ST_FETCH;
            ST_MEMWR:  state_nxt_s = mem_ready ? ST_FETCH : (timeout_s ? ST_ERR : ST_MEMWR);
            ST_EXEC:   state_nxt_s = ST_ALUWB;
            ST_ALUWB:  state_nxt_s = ST_FETCH;
            ST_BRANCH: state_nxt_s = ST_FETCH;
            ST_ADDIWB: state_nxt_s = ST_FETCH;
            ST_JAL:    state_nxt_s = ST_FETCH;
            ST_JR:     state_nxt_s = ST_FETCH;
            ST_HALT:   state_nxt_s = ST_HALT;
            ST_ERR:    state_nxt_s = ST_ERR;
            default:   state_nxt_s = ST_ERR;
        endcase
    end

    // Control outputs for the state being entered, captured at the edge
    always_comb begin
        ctrl_nxt_s = '0;
        case (state_nxt_s)
            ST_FETCH: begin
                ctrl_nxt_s.mem_req   = 1'b1;
                ctrl_nxt_s.alu_src_b = SRCB_FOUR;
                ctrl_nxt_s.alu_ctrl  = ALU_ADD;
                ctrl_nxt_s.pc_src    = PC_ALU;
            end
            ST_DECODE: begin
                ctrl_nxt_s.alu_src_b = SRCB_IMM_SH;
                ctrl_nxt_s.alu_ctrl  = ALU_ADD;
            end
            ST_MEMADR: begin
                ctrl_nxt_s.alu_src_a = 1'b1;
                ctrl_nxt_s.alu_src_b = SRCB_IMM;
                ctrl_nxt_s.alu_ctrl  = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl_nxt_s.mem_req = 1'b1;
                ctrl_nxt_s.iord    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_nxt_s.reg_we  = 1'b1;
                ctrl_nxt_s.reg_dst = RD_RT;
                ctrl_nxt_s.wb_sel  = WB_MEM;
            end
            ST_MEMWR: begin
                ctrl_nxt_s.mem_req = 1'b1;
                ctrl_nxt_s.mem_we  = 1'b1;
                ctrl_nxt_s.iord    = 1'b1;
            end
            ST_EXEC: begin
                ctrl_nxt_s.alu_src_a = 1'b1;
                ctrl_nxt_s.alu_src_b = SRCB_RT;
                ctrl_nxt_s.alu_ctrl  = dec_alu_ctrl_s;
            end
            ST_ALUWB: begin
                ctrl_nxt_s.reg_we  = 1'b1;
                ctrl_nxt_s.reg_dst = RD_RD;
                ctrl_nxt_s.wb_sel  = WB_ALUOUT;
            end
            ST_ADDIWB: begin
                ctrl_nxt_s.reg_we  = 1'b1;
                ctrl_nxt_s.reg_dst = RD_RT;
                ctrl_nxt_s.wb_sel  = WB_ALUOUT;
            end
            ST_BRANCH: begin
                ctrl_nxt_s.alu_src_a = 1'b1;
                ctrl_nxt_s.alu_src_b = SRCB_RT;
                ctrl_nxt_s.alu_ctrl  = ALU_SUB;
                ctrl_nxt_s.pc_src    = PC_ALUOUT;
            end
            ST_JAL: begin
                ctrl_nxt_s.reg_we  = 1'b1;
                ctrl_nxt_s.reg_dst = RD_R31;
                ctrl_nxt_s.wb_sel  = WB_PC;
                ctrl_nxt_s.pc_src  = PC_JUMP;
            end
            ST_JR: begin
                ctrl_nxt_s.pc_src = PC_RS;
            end
            ST_HALT: begin
                ctrl_nxt_s.halted = 1'b1;
            end
            ST_ERR: begin
                ctrl_nxt_s.halted = 1'b1;
                ctrl_nxt_s.err    = 1'b1;
            end
            default: ctrl_nxt_s = '0;
        endcase
    end

    // Input-dependent strobes: fetch completion and branch decision
    always_comb begin
        pc_we = 1'b0;
        ir_we = 1'b0;
        case (state_r)
            ST_FETCH: begin
                pc_we = mem_ready;
                ir_we = mem_ready;
            end
            ST_BRANCH: pc_we = zero ^ (op == OP_BNE);
            ST_JAL:    pc_we = 1'b1;
            ST_JR:     pc_we = 1'b1;
            default: begin
                pc_we = 1'b0;
                ir_we = 1'b0;
            end
        endcase
    end

    assign mem_req   = ctrl_r.mem_req;
    assign mem_we    = ctrl_r.mem_we;
    assign iord      = ctrl_r.iord;
    assign pc_src    = ctrl_r.pc_src;
    assign reg_we    = ctrl_r.reg_we;
    assign reg_dst   = ctrl_r.reg_dst;
    assign wb_sel    = ctrl_r.wb_sel;
    assign alu_src_a = ctrl_r.alu_src_a;
    assign alu_src_b = ctrl_r.alu_src_b;
    assign alu_ctrl  = ctrl_r.alu_ctrl;
    assign halted    = ctrl_r.halted;
    assign err       = ctrl_r.err;
    assign state     = state_r;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl. Each instruction is expanded into a per-cycle plan
// of expected state codes and mem_ready values; a table of per-state output
// values gives the expected control vector for every cycle.
module tb_mips_mc_ctrl;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src_a, halted, err;
    logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic [19:0] dut_vec;

    mips_mc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .halted(halted), .err(err),
        .state(state)
    );

    always #5 clk = ~clk;

    assign dut_vec = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                      wb_sel, alu_src_a, alu_src_b, alu_ctrl, halted, err};

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
    } cyc_t;

    cyc_t plan[$];
    cyc_t cur;
    bit   chk_en = 1'b0;
    int   cyc_idx = 0;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] b_op = 6'd0;
    logic [5:0] b_fn = 6'd0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // R-type funct table: which ones execute and what ALU code they use
    function automatic bit fn_ok(logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) || (f == 6'b100101) ||
               (f == 6'b101010) || (f == 6'b000000) || (f == 6'b000010);
    endfunction

    function automatic logic [2:0] fn_alu(logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            6'b000000: return 3'b100;
            6'b000010: return 3'b101;
            default:   return 3'b000;
        endcase
    endfunction

    // Expected output vector for one cycle, straight from the per-state rules
    function automatic logic [19:0] exp_out(cyc_t c);
        logic mreq = 0, mwe = 0, io = 0, irw = 0, pcw = 0, rw = 0, sa = 0, hl = 0, er = 0;
        logic [1:0] pcs = 0, rd = 0, wb = 0, sb = 0;
        logic [2:0] alu = 0;
        case (c.st)
            4'd1:  begin mreq = 1; sb = 2'b01; alu = 3'b010; irw = c.mr; pcw = c.mr; end
            4'd2:  begin sb = 2'b11; alu = 3'b010; end
            4'd3:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            4'd4:  begin mreq = 1; io = 1; end
            4'd5:  begin rw = 1; rd = 2'b00; wb = 2'b01; end
            4'd6:  begin mreq = 1; mwe = 1; io = 1; end
            4'd7:  begin sa = 1; sb = 2'b00; alu = fn_alu(c.fn); end
            4'd8:  begin rw = 1; rd = 2'b01; wb = 2'b00; end
            4'd9:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pcw = c.z ^ (c.op == 6'b000101); end
            4'd10: begin rw = 1; rd = 2'b00; wb = 2'b00; end
            4'd11: begin rw = 1; rd = 2'b10; wb = 2'b10; pcw = 1; pcs = 2'b10; end
            4'd12: begin pcw = 1; pcs = 2'b11; end
            4'd13: begin hl = 1; end
            4'd14: begin hl = 1; er = 1; end
            default: ;
        endcase
        return {mreq, mwe, io, irw, pcw, pcs, rw, rd, wb, sa, sb, alu, hl, er};
    endfunction

    function automatic void add(logic [3:0] st, logic mr, logic zb);
        cyc_t c;
        int n = plan.size();
        c.st = st; c.mr = mr; c.op = b_op; c.fn = b_fn;
        c.z = (st == 4'd9) ? zb : n[0];
        plan.push_back(c);
    endfunction

    // Cycle where mem_ready and zero are don't-cares: toggle them
    function automatic void idle(logic [3:0] st);
        int n = plan.size();
        add(st, ~n[0], 1'b0);
    endfunction

    // Expand one instruction into cycles; fw/mw = wait cycles before mem_ready
    function automatic int build(logic [5:0] o, logic [5:0] f, logic zb, int fw, int mw);
        int start = plan.size();
        b_op = o; b_fn = f;
        for (int k = 0; k < fw && k < WAIT_MAX; k++) add(4'd1, 1'b0, 1'b0);
        if (fw >= WAIT_MAX) begin
            for (int k = 0; k < 4; k++) idle(4'd14);
            return plan.size() - start;
        end
        add(4'd1, 1'b1, 1'b0);
        idle(4'd2);
        if (o == 6'b000000) begin
            if (f == 6'b001000) idle(4'd12);
            else if (fn_ok(f)) begin idle(4'd7); idle(4'd8); end
            else for (int k = 0; k < 3; k++) idle(4'd13);
        end else if (o == 6'b100011) begin
            idle(4'd3);
            for (int k = 0; k < mw; k++) add(4'd4, 1'b0, 1'b0);
            add(4'd4, 1'b1, 1'b0);
            idle(4'd5);
        end else if (o == 6'b101011) begin
            idle(4'd3);
            for (int k = 0; k < mw; k++) add(4'd6, 1'b0, 1'b0);
            add(4'd6, 1'b1, 1'b0);
        end else if (o == 6'b001000) begin
            idle(4'd3); idle(4'd10);
        end else if (o == 6'b000100 || o == 6'b000101) begin
            add(4'd9, 1'b0, zb);
        end else if (o == 6'b000011) begin
            idle(4'd11);
        end else begin
            for (int k = 0; k < 3; k++) idle(4'd13);
        end
        return plan.size() - start;
    endfunction

    // Compare DUT outputs against the plan on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check($sformatf("cyc%0d state", cyc_idx), 32'(state), 32'(cur.st));
            check($sformatf("cyc%0d outputs st=%0d", cyc_idx, cur.st), 32'(dut_vec), 32'(exp_out(cur)));
        end
    end

    task automatic run_plan();
        for (int i = 0; i < plan.size(); i++) begin
            @(posedge clk); #1;
            cur = plan[i]; cyc_idx = i;
            op = plan[i].op; funct = plan[i].fn; zero = plan[i].z; mem_ready = plan[i].mr;
            chk_en = 1'b1;
        end
        @(negedge clk); #1;
        chk_en = 1'b0;
        plan.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        check("reset state", 32'(state), 32'd0);
        check("reset outputs", 32'(dut_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Mixed instruction stream ending in HALT via unsupported funct
        idle(4'd0);
        n = build(6'b000000, 6'b100000, 1'b0, 0, 0);  check("len rtype", n, 32'd4);
        n = build(6'b000000, 6'b100010, 1'b0, 2, 0);  check("len rtype fw2", n, 32'd6);
        n = build(6'b000000, 6'b000000, 1'b0, 0, 0);
        n = build(6'b000000, 6'b000010, 1'b0, 0, 0);
        n = build(6'b000000, 6'b100100, 1'b0, 1, 0);
        n = build(6'b000000, 6'b100101, 1'b0, 0, 0);
        n = build(6'b000000, 6'b101010, 1'b0, 0, 0);
        n = build(6'b000000, 6'b001000, 1'b0, 0, 0);  check("len jr", n, 32'd3);
        n = build(6'b000100, 6'b000000, 1'b1, 0, 0);  check("len beq", n, 32'd3);
        n = build(6'b000100, 6'b000000, 1'b0, 0, 0);
        n = build(6'b000101, 6'b000000, 1'b0, 0, 0);
        n = build(6'b000101, 6'b000000, 1'b1, 0, 0);
        n = build(6'b001000, 6'b000000, 1'b0, 0, 0);  check("len addi", n, 32'd4);
        n = build(6'b100011, 6'b000000, 1'b0, 0, 3);  check("len lw mw3", n, 32'd8);
        n = build(6'b101011, 6'b000000, 1'b0, 0, 2);
        n = build(6'b101011, 6'b000000, 1'b0, 0, 0);  check("len sw", n, 32'd4);
        n = build(6'b100011, 6'b000000, 1'b0, WAIT_MAX - 1, 0);
        n = build(6'b000011, 6'b000000, 1'b0, 0, 0);  check("len jal", n, 32'd3);
        n = build(6'b000000, 6'b111111, 1'b0, 0, 0);
        do_reset();
        run_plan();
        check("halt sticky halted", 32'(halted), 32'd1);

        // Unsupported opcode halts; no further memory requests
        idle(4'd0);
        n = build(6'b111111, 6'b000000, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) idle(4'd13);
        do_reset();
        run_plan();
        check("halt no mem_req", 32'(mem_req), 32'd0);

        // Fetch timeout: mem_ready never comes
        idle(4'd0);
        n = build(6'b000000, 6'b100000, 1'b0, WAIT_MAX, 0);  check("len timeout", n, 32'd19);
        do_reset();
        run_plan();
        check("timeout err", 32'(err), 32'd1);
        check("timeout halted", 32'(halted), 32'd1);

        // Asynchronous reset in the middle of a stalled store
        idle(4'd0);
        n = build(6'b101011, 6'b000000, 1'b0, 0, 6);
        repeat (5) void'(plan.pop_back());
        do_reset();
        run_plan();
        check("pre-reset mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset state", 32'(state), 32'd0);
        check("async reset mem_we", 32'(mem_we), 32'd0);
        check("async reset mem_req", 32'(mem_req), 32'd0);
        check("async reset pc_we", 32'(pc_we), 32'd0);

        // Restart after the pulse: FETCH two edges after release
        idle(4'd0);
        n = build(6'b000000, 6'b100101, 1'b0, 0, 0);
        do_reset();
        run_plan();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
